// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Converts an unsigned binary value to BCD (shift-add-3) and
//            drives a multiplexed common-select 7-segment display, with
//            optional leading-zero blanking and an overflow ("-") indication.
// Ports    : clk      - single clock, rising edge
//            rst      - synchronous active-high reset
//            bin_in   - [BIN_W-1:0] value to display, captured on load
//            load     - capture request, honoured only while busy=0
//            busy     - conversion in progress
//            ovf      - displayed value exceeds 10^DIGITS-1
//            seg_out  - [6:0] segments {a,b,c,d,e,f,g}, bit 6 = a
//            sel      - [DIGITS-1:0] active-low one-hot digit enable,
//                       bit 0 = units digit
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int BIN_W          = 14,
    parameter int DIV            = 100000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int BLANK_LZ       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  bin_in,
    input  logic              load,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg_out,
    output logic [DIGITS-1:0] sel
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(BIN_W);
    localparam int c_PRE_W = $clog2(DIV);
    localparam int c_IDX_W = $clog2(DIGITS);

    function automatic logic [63:0] f_pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Largest value representable on the display.
    localparam logic [63:0] c_MAX = f_pow10(DIGITS) - 64'd1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [BIN_W-1:0]   r_bin;
    logic [c_BCD_W-1:0] r_bcd;
    logic [c_BCD_W-1:0] w_bcd_adj;
    logic [c_BCD_W-1:0] w_bcd_shift;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovf_cap;
    logic [c_BCD_W-1:0] r_disp;
    logic               r_ovf;
    logic [c_PRE_W-1:0] r_pre;
    logic [c_IDX_W-1:0] r_idx;
    logic               w_capture;

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_CNT_W'(BIN_W - 1)) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_capture = (r_state == S_IDLE) && load;
    assign busy      = (r_state != S_IDLE);
    assign ovf       = r_ovf;

    // Add 3 to every nibble >= 5, then shift the next binary MSB in.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_shift = {w_bcd_adj[c_BCD_W-2:0], r_bin[BIN_W-1]};

    // ------------------------------------------------------------------
    // Conversion datapath and display register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovf_cap <= 1'b0;
            r_disp    <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_capture) begin
                r_bin     <= bin_in;
                r_bcd     <= '0;
                r_cnt     <= '0;
                // Overflow is decided on the raw binary value, since the BCD
                // register cannot hold digits beyond DIGITS.
                r_ovf_cap <= ({{(64-BIN_W){1'b0}}, bin_in} > c_MAX);
            end else if (r_state == S_SHIFT) begin
                r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                r_bcd <= w_bcd_shift;
                r_cnt <= r_cnt + 1'b1;
            end
            // Display only changes here, so a partial result is never shown.
            if (r_state == S_COMMIT) begin
                r_disp <= r_bcd;
                r_ovf  <= r_ovf_cap;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan prescaler and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == c_PRE_W'(DIV - 1)) begin
            r_pre <= '0;
            if (r_idx == c_IDX_W'(DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Digit select and segment decode (pure function of registers)
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] w_lz_mask;
    logic              w_run;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [6:0]        w_pat;
    logic [DIGITS-1:0] w_onehot;

    // w_lz_mask[i] = digit i and every digit above it are zero.
    always_comb begin
        w_run     = 1'b1;
        w_lz_mask = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_run        = w_run && (r_disp[4*i +: 4] == 4'd0);
            w_lz_mask[i] = w_run;
        end
    end

    always_comb begin
        w_nib   = 4'd0;
        w_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nib   = r_disp[4*i +: 4];
                w_blank = (BLANK_LZ != 0) && (i != 0) && w_lz_mask[i];
            end
        end
    end

    always_comb begin
        w_pat = 7'b0000000;
        if (r_ovf) begin
            w_pat = 7'b0000001;
        end else if (!w_blank) begin
            case (w_nib)
                4'd0:    w_pat = 7'b1111110;
                4'd1:    w_pat = 7'b0110000;
                4'd2:    w_pat = 7'b1101101;
                4'd3:    w_pat = 7'b1111001;
                4'd4:    w_pat = 7'b0110011;
                4'd5:    w_pat = 7'b1011011;
                4'd6:    w_pat = 7'b1011111;
                4'd7:    w_pat = 7'b1110000;
                4'd8:    w_pat = 7'b1111111;
                4'd9:    w_pat = 7'b1111011;
                default: w_pat = 7'b0000000;
            endcase
        end
    end

    assign seg_out  = (SEG_ACTIVE_LOW != 0) ? ~w_pat : w_pat;
    assign w_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
    assign sel      = ~w_onehot;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Directed self-checking bench for seg7_scan_driver. Two
//            instances share stimulus: one with default polarity and
//            leading-zero blanking, one active-low without blanking.
//            Expected digit patterns are queued when a value is driven and
//            popped as the display scans through the digits.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int DIV    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [BIN_W-1:0] bin_in;
    logic             busy1, ovf1, busy2, ovf2;
    logic [6:0]       seg1, seg2;
    logic [3:0]       sel1, sel2;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .DIV(DIV),
        .SEG_ACTIVE_LOW(0), .BLANK_LZ(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .bin_in(bin_in), .load(load),
        .busy(busy1), .ovf(ovf1), .seg_out(seg1), .sel(sel1)
    );

    seg7_scan_driver #(
        .DIGITS(DIGITS), .BIN_W(BIN_W), .DIV(DIV),
        .SEG_ACTIVE_LOW(1), .BLANK_LZ(0)
    ) u_dut2 (
        .clk(clk), .rst(rst), .bin_in(bin_in), .load(load),
        .busy(busy2), .ovf(ovf2), .seg_out(seg2), .sel(sel2)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg1;
        logic [6:0] seg2;
    } exp_t;

    exp_t sb[$];

    function automatic logic [6:0] lut(input int n);
        case (n)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int pow10(input int n);
        int r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    // Reference pattern for digit d of value v.
    function automatic logic [6:0] model_seg(input int v, input int d,
                                             input bit blz, input bit alow);
        logic [6:0] p;
        if (v > pow10(DIGITS) - 1)
            p = 7'b0000001;
        else if (blz && d != 0 && v < pow10(d))
            p = 7'b0000000;
        else
            p = lut((v / pow10(d)) % 10);
        return alow ? ~p : p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int v);
        exp_t e;
        logic [3:0] one;
        for (int d = 0; d < DIGITS; d++) begin
            one    = 4'b0001 << d;
            e.sel  = ~one;
            e.seg1 = model_seg(v, d, 1'b1, 1'b0);
            e.seg2 = model_seg(v, d, 1'b0, 1'b1);
            sb.push_back(e);
        end
    endtask

    // Align to the first cycle of digit 0, then compare one slot per digit.
    task automatic check_scan(input string tag);
        int   n = 0;
        exp_t e;
        while (sel1 == 4'b1110 && n < 40) begin tick(); n++; end
        while (sel1 != 4'b1110 && n < 40) begin tick(); n++; end
        check({tag, "_sync"}, 32'(n < 40), 32'd1);
        for (int d = 0; d < DIGITS; d++) begin
            if (sb.size() == 0) begin
                check($sformatf("%s_d%0d_empty", tag, d), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s_d%0d_sel1", tag, d), 32'(sel1), 32'(e.sel));
                check($sformatf("%s_d%0d_seg1", tag, d), 32'(seg1), 32'(e.seg1));
                check($sformatf("%s_d%0d_sel2", tag, d), 32'(sel2), 32'(e.sel));
                check($sformatf("%s_d%0d_seg2", tag, d), 32'(seg2), 32'(e.seg2));
            end
            repeat (DIV) tick();
        end
    endtask

    // Load a value, return number of cycles busy stayed high.
    task automatic do_load(input int v, output int lat);
        push_exp(v);
        bin_in = BIN_W'(v);
        load   = 1'b1;
        tick();
        load   = 1'b0;
        lat    = 0;
        while (busy1 && lat < 40) begin lat++; tick(); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int n;

        rst    = 1'b1;
        load   = 1'b0;
        bin_in = '0;
        repeat (3) tick();
        push_exp(0);
        rst = 1'b0;
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_ovf1",  32'(ovf1),  32'd0);
        check("rst_sel1",  32'(sel1),  32'b1110);
        check("rst_seg1",  32'(seg1),  32'b1111110);
        check("rst_sel2",  32'(sel2),  32'b1110);
        check("rst_seg2",  32'(seg2),  32'b0000001);
        check_scan("reset");

        do_load(1234, lat);
        check("1234_lat", 32'(lat), 32'd15);
        check("1234_ovf", 32'(ovf1), 32'd0);
        check_scan("v1234");

        do_load(9999, lat);
        check("9999_lat", 32'(lat), 32'd15);
        check("9999_ovf", 32'(ovf1), 32'd0);
        check_scan("v9999");

        do_load(10000, lat);
        check("10000_ovf1", 32'(ovf1), 32'd1);
        check("10000_ovf2", 32'(ovf2), 32'd1);
        check_scan("v10000");

        // 57 with a second load pulsed mid-conversion (must be ignored).
        push_exp(57);
        bin_in = BIN_W'(57);
        load   = 1'b1;
        tick();
        load   = 1'b0;
        repeat (4) tick();
        bin_in = BIN_W'(8000);
        load   = 1'b1;
        tick();
        load   = 1'b0;
        bin_in = '0;
        check("57_busy_mid", 32'(busy1), 32'd1);
        check("57_ovf_hold", 32'(ovf1), 32'd1);
        n = 5;
        while (busy1 && n < 40) begin n++; tick(); end
        check("57_lat", 32'(n), 32'd15);
        check("57_ovf_clr", 32'(ovf1), 32'd0);
        check_scan("v57");

        // Abort 4321 with reset sampled at the end of the 7th SHIFT cycle.
        bin_in = BIN_W'(4321);
        load   = 1'b1;
        tick();
        load   = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_exp(0);
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_ovf",  32'(ovf1),  32'd0);
        check("abort_sel",  32'(sel1),  32'b1110);
        check("abort_seg",  32'(seg1),  32'b1111110);
        repeat (DIV - 1) tick();
        check("abort_sel_hold", 32'(sel1), 32'b1110);
        tick();
        check("abort_sel_adv",  32'(sel1), 32'b1101);
        check_scan("abort");

        // Reset and load together: reset wins.
        rst    = 1'b1;
        load   = 1'b1;
        bin_in = BIN_W'(9999);
        tick();
        rst    = 1'b0;
        load   = 1'b0;
        bin_in = '0;
        check("rstload_busy0", 32'(busy1), 32'd0);
        repeat (2) tick();
        check("rstload_busy1", 32'(busy1), 32'd0);
        push_exp(0);
        check_scan("rstload");

        do_load(4321, lat);
        check("4321_lat", 32'(lat), 32'd15);
        check_scan("v4321");

        do_load(7, lat);
        check("7_lat", 32'(lat), 32'd15);
        check("7_ovf2", 32'(ovf2), 32'd0);
        check_scan("v7");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
